// File: rtl/phy_pkg.sv
// Shared definitions for the phy_tx interleaver and phy_rx lane demux.
// Holds the alignment symbol, the lane geometry and the rx state encoding.
package phy_pkg;

  localparam logic [7:0] COM_SYM   = 8'hBC;
  localparam int         NUM_LANES = 4;
  localparam int         BYTE_W    = 8;

  typedef enum logic {
    HUNT    = 1'b0,
    ALIGNED = 1'b1
  } rx_state_t;

endpackage

// File: rtl/phy_rx_align_fsm.sv
// Lock / slot-tracking controller for the rx lane demux: follows the frame position
// and tells the datapath when to capture lane 0, store a hold byte, or load a frame.
//
//  state   | meaning
//  HUNT    | no lock; waiting for a valid COM to mark lane 0
//  ALIGNED | locked; slot advances every cycle, frame loads at slot 3
module phy_rx_align_fsm
  import phy_pkg::*;
#(
  parameter int IDLE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [1:0]        slot,
  output logic              capture,
  output logic              store,
  output logic              load,
  output logic              aligned,
  output logic              align_err
);

  localparam logic [3:0] IDLE_LIM = IDLE_LIMIT[3:0];

  rx_state_t  state;
  logic [3:0] idle_cnt;
  logic [3:0] idle_next;
  logic       seen;
  logic       frame_any;
  logic       is_com;
  logic       misalign;

  assign is_com    = valid_in && (data_in == COM_SYM);
  assign misalign  = (state == ALIGNED) && is_com && (slot != 2'd0);
  assign capture   = is_com && ((state == HUNT) || (slot != 2'd0));
  assign store     = (state == ALIGNED) && !misalign && (slot != 2'd3);
  assign load      = (state == ALIGNED) && !misalign && (slot == 2'd3);
  assign frame_any = seen | valid_in;
  assign idle_next = (idle_cnt == 4'hF) ? idle_cnt : idle_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      slot      <= 2'd0;
      idle_cnt  <= 4'd0;
      seen      <= 1'b0;
      aligned   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      case (state)
        HUNT: begin
          if (is_com) begin
            state   <= ALIGNED;
            aligned <= 1'b1;
            slot    <= 2'd1;
            seen    <= 1'b1;
          end
        end
        ALIGNED: begin
          if (misalign) begin
            // COM restarts the frame; the partial one is dropped by not loading it
            align_err <= 1'b1;
            slot      <= 2'd1;
            seen      <= 1'b1;
          end else if (slot == 2'd3) begin
            slot <= 2'd0;
            seen <= 1'b0;
            if (frame_any) begin
              idle_cnt <= 4'd0;
            end else if (idle_next >= IDLE_LIM) begin
              state    <= HUNT;
              aligned  <= 1'b0;
              idle_cnt <= 4'd0;
            end else begin
              idle_cnt <= idle_next;
            end
          end else begin
            slot <= slot + 2'd1;
            seen <= frame_any;
          end
        end
        default: begin
          state   <= HUNT;
          aligned <= 1'b0;
          slot    <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_lane_demux.sv
// Rebuilds 4 parallel byte lanes from the interleaved serial stream.
// Lanes 0..2 are parked in hold registers; the whole frame loads on the lane-3 byte.
module phy_rx_lane_demux
  import phy_pkg::*;
#(
  parameter int IDLE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [BYTE_W-1:0] out0,
  output logic [BYTE_W-1:0] out1,
  output logic [BYTE_W-1:0] out2,
  output logic [BYTE_W-1:0] out3,
  output logic              valid0,
  output logic              valid1,
  output logic              valid2,
  output logic              valid3,
  output logic              frame_valid,
  output logic              aligned,
  output logic              align_err
);

  logic [1:0]        slot;
  logic              capture;
  logic              store;
  logic              load;
  logic [BYTE_W-1:0] hold0, hold1, hold2;
  logic              hold_v0, hold_v1, hold_v2;

  phy_rx_align_fsm #(.IDLE_LIMIT(IDLE_LIMIT)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .slot      (slot),
    .capture   (capture),
    .store     (store),
    .load      (load),
    .aligned   (aligned),
    .align_err (align_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold0   <= '0;
      hold1   <= '0;
      hold2   <= '0;
      hold_v0 <= 1'b0;
      hold_v1 <= 1'b0;
      hold_v2 <= 1'b0;
    end else if (capture) begin
      hold0   <= data_in;
      hold_v0 <= 1'b1;
    end else if (store) begin
      case (slot)
        2'd0: begin hold0 <= data_in; hold_v0 <= valid_in; end
        2'd1: begin hold1 <= data_in; hold_v1 <= valid_in; end
        2'd2: begin hold2 <= data_in; hold_v2 <= valid_in; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
      valid2      <= 1'b0;
      valid3      <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= load;
      if (load) begin
        out0   <= hold0;
        out1   <= hold1;
        out2   <= hold2;
        out3   <= data_in;
        valid0 <= hold_v0;
        valid1 <= hold_v1;
        valid2 <= hold_v2;
        valid3 <= valid_in;
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_lane_demux.sv
// Directed bench for phy_rx_lane_demux: hand-computed vectors, immediate assertions.
module tb_phy_rx_lane_demux;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       valid0, valid1, valid2, valid3;
  logic       frame_valid, aligned, align_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phy_rx_lane_demux #(.IDLE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .valid0      (valid0),
    .valid1      (valid1),
    .valid2      (valid2),
    .valid3      (valid3),
    .frame_valid (frame_valid),
    .aligned     (aligned),
    .align_err   (align_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive on the falling edge, return 1ns after the rising edge
  task automatic step(input logic [7:0] d, input logic v);
    @(negedge clk);
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] bytes, input logic [3:0] v);
    check({tag, "_out"}, {out0, out1, out2, out3}, bytes);
    check({tag, "_valid"}, {28'd0, valid0, valid1, valid2, valid3}, {28'd0, v});
    check({tag, "_fv"}, {31'd0, frame_valid}, 32'd1);
  endtask

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {out0, out1, out2, out3}, 32'h0);
    check("rst_flags", {27'd0, valid0, valid1, valid2, valid3, frame_valid}, 32'd0);
    check("rst_aligned", {30'd0, aligned, align_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // lock and two frames
    step(8'hBC, 1'b1);
    check("lock_aligned", {31'd0, aligned}, 32'd1);
    step(8'hEE, 1'b1);
    step(8'hDD, 1'b1);
    check("pre_load_fv", {31'd0, frame_valid}, 32'd0);
    check("pre_load_out", {out0, out1, out2, out3}, 32'h0);
    step(8'hCC, 1'b1);
    check_frame("frame1", 32'hBCEEDDCC, 4'b1111);
    step(8'hBB, 1'b1);
    check("fv_pulse_end", {31'd0, frame_valid}, 32'd0);
    check("hold_between", {out0, out1, out2, out3}, 32'hBCEEDDCC);
    step(8'hAA, 1'b1);
    step(8'h99, 1'b1);
    step(8'h88, 1'b1);
    check_frame("frame2", 32'hBBAA9988, 4'b1111);

    // per-lane valid
    step(8'h55, 1'b0);
    step(8'h55, 1'b0);
    step(8'h77, 1'b1);
    step(8'h55, 1'b0);
    check_frame("perlane", 32'h55557755, 4'b0010);

    // misaligned COM at slot 1
    step(8'h44, 1'b1);
    step(8'hBC, 1'b1);
    check("mis1_err", {30'd0, align_err, frame_valid}, 32'd2);
    check("mis1_aligned", {31'd0, aligned}, 32'd1);
    step(8'h11, 1'b1);
    check("mis1_err_end", {31'd0, align_err}, 32'd0);
    step(8'h22, 1'b1);
    check("mis1_hold", {out0, out1, out2, out3}, 32'h55557755);
    step(8'h33, 1'b1);
    check_frame("mis1", 32'hBC112233, 4'b1111);

    // misaligned COM at slot 3 wins over frame load
    step(8'h10, 1'b1);
    step(8'h20, 1'b1);
    step(8'h30, 1'b1);
    step(8'hBC, 1'b1);
    check("mis3_err", {30'd0, align_err, frame_valid}, 32'd2);
    check("mis3_hold", {out0, out1, out2, out3}, 32'hBC112233);
    step(8'h61, 1'b1);
    step(8'h62, 1'b1);
    step(8'h63, 1'b1);
    check_frame("mis3", 32'hBC616263, 4'b1111);

    // COM at slot 0 while aligned is plain data
    step(8'hBC, 1'b1);
    check("com_slot0_err", {31'd0, align_err}, 32'd0);
    step(8'h01, 1'b1);
    step(8'h02, 1'b0);
    step(8'h03, 1'b1);
    check_frame("com_slot0", 32'hBC010203, 4'b1101);

    // idle loss after four all-invalid frames
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < 4; s++) step(8'h00, 1'b0);
      check_frame("idle", 32'h0, 4'b0000);
      check("idle_aligned", {31'd0, aligned}, (f == 3) ? 32'd0 : 32'd1);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(8'h40 + 8'(i), 1'b1);
      if (frame_valid) pulses++;
    end
    check("hunt_no_fv", pulses, 0);
    check("hunt_aligned", {31'd0, aligned}, 32'd0);

    // HUNT ignores non-COM bytes and an invalid COM
    step(8'hFF, 1'b1);
    step(8'hEE, 1'b1);
    step(8'hBC, 1'b0);
    check("filter_invalid_com", {31'd0, aligned}, 32'd0);
    step(8'hBC, 1'b1);
    check("filter_lock", {31'd0, aligned}, 32'd1);
    step(8'h01, 1'b1);
    step(8'h02, 1'b1);
    step(8'h03, 1'b1);
    check_frame("filter", 32'hBC010203, 4'b1111);

    // asynchronous reset mid-frame
    step(8'hBC, 1'b1);
    step(8'hAA, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_out", {out0, out1, out2, out3}, 32'h0);
    check("async_flags", {25'd0, valid0, valid1, valid2, valid3, frame_valid, aligned, align_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(8'h21, 1'b1);
      if (frame_valid || aligned) pulses++;
    end
    check("post_rst_hunt", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
